bus_arbiter: RTL and testbench

Central arbiter for the shared 8-bit tri-state crypto data bus. It collects requests from the three datapath modules (IDs 0-2) and the control module (ID 3) and grants one owner at a time. It monitors the header beat and counts frame beats. It ends a tenure on ack, and inserts a turnaround cycle before the next grant so that no two drivers overlap on bus_data or bus_valid.

---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_arbiter_rr_pick.sv | 26 ++
 rtl/bus_arbiter.sv | 144 ++++++++++++++
 tb/tb_bus_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the crypto data bus: arbiter states, IDs, header layout, error codes.
package bus_pkg;
  typedef enum logic [1:0] {IDLE, HDR, XFER, TURN} state_t;

  localparam logic [1:0] ID_CTRL = 2'd3;
  localparam int         SRC_LSB = 2;
  localparam int         DST_LSB = 4;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SRC  = 2'd1;
  localparam logic [1:0] ERR_LEN  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  // Datapath IDs rotate 0 -> 1 -> 2 -> 0; control never enters the rotation.
  function automatic logic [1:0] rr_next(input logic [1:0] id);
    return (id == 2'd2) ? 2'd0 : id + 2'd1;
  endfunction
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational 3-way round-robin picker: first requester at or after ptr wins.
module rr_pick (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] win,
  output logic [1:0] win_id
);
  logic [2:0] s;
  logic       found;

  always_comb begin
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    s      = '0;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, ptr} + 3'(i);
      if (s >= 3'd3) s = s - 3'd3;
      if (!found && req[s[1:0]]) begin
        found          = 1'b1;
        win[s[1:0]]    = 1'b1;
        win_id         = s[1:0];
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Shared crypto bus arbiter: grant, header monitor, beat count, turnaround.
// Optional stall timeout enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BEATS   = 64,
  parameter int TURNAROUND  = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               bus_valid,
  input  logic [7:0]         bus_data,
  input  logic               ack,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         owner_id,
  output logic               bus_busy,
  output logic [1:0]         hdr_src,
  output logic [1:0]         hdr_dst,
  output logic               hdr_valid,
  output logic               frame_done,
  output logic [1:0]         err
);
  localparam logic [6:0] MAX_B     = 7'(MAX_BEATS);
  localparam logic [1:0] TURN_LOAD = 2'(TURNAROUND - 1);

  state_t             state;
  logic [1:0]         ptr;
  logic [6:0]         beat_cnt, beat_nxt;
  logic [1:0]         turn_cnt;
  logic [2:0]         rr_win;
  logic [1:0]         rr_id, win_id, bus_src;
  logic [NUM_REQ-1:0] win_oh;
  logic               src_bad, tmo, fin;
  logic [1:0]         fin_err;
  logic               unused_bits;

  rr_pick u_rr (.req(req[2:0]), .ptr(ptr), .win(rr_win), .win_id(rr_id));

  assign bus_src  = bus_data[SRC_LSB+:2];
  assign src_bad  = (owner_id != ID_CTRL) && (bus_src != owner_id);
  assign beat_nxt = (beat_cnt == 7'h7f) ? beat_cnt : beat_cnt + 7'd1;
  assign win_id   = req[ID_CTRL] ? ID_CTRL : rr_id;

  always_comb begin
    win_oh = '0;
    if (req[ID_CTRL]) win_oh[ID_CTRL] = 1'b1;
    else              win_oh[2:0]     = rr_win;
  end

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] idle_cnt;
  assign tmo = !bus_valid && (idle_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     idle_cnt <= '0;
    else if (bus_valid || !(state inside {HDR, XFER})) idle_cnt <= '0;
    else                                            idle_cnt <= idle_cnt + 8'd1;
  end
  assign unused_bits = ^{bus_data[7:6], bus_data[1:0]};
`else
  assign tmo         = 1'b0;
  assign unused_bits = ^{bus_data[7:6], bus_data[1:0], 32'(TIMEOUT_CYC)};
`endif

  // Tenure end: a source mismatch beats a same-cycle ack, so a bad frame never reports done.
  always_comb begin
    fin     = 1'b0;
    fin_err = ERR_NONE;
    case (state)
      HDR: begin
        if (bus_valid) begin
          if (src_bad)  begin fin = 1'b1; fin_err = ERR_SRC; end
          else if (ack) fin = 1'b1;
        end else if (tmo) begin
          fin = 1'b1; fin_err = ERR_TMO;
        end
      end
      XFER: begin
        if (bus_valid) begin
          if (ack)                     fin = 1'b1;
          else if (beat_nxt >= MAX_B) begin fin = 1'b1; fin_err = ERR_LEN; end
        end else if (tmo) begin
          fin = 1'b1; fin_err = ERR_TMO;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      beat_cnt   <= '0;
      turn_cnt   <= '0;
      gnt        <= '0;
      owner_id   <= '0;
      bus_busy   <= 1'b0;
      hdr_src    <= '0;
      hdr_dst    <= '0;
      hdr_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= ERR_NONE;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          gnt      <= win_oh;
          owner_id <= win_id;
          bus_busy <= 1'b1;
          state    <= HDR;
        end
        HDR: if (bus_valid) begin
          hdr_src   <= bus_src;
          hdr_dst   <= bus_data[DST_LSB+:2];
          hdr_valid <= 1'b1;
          beat_cnt  <= 7'd1;
          state     <= XFER;
        end
        XFER: if (bus_valid) beat_cnt <= beat_nxt;
        TURN: begin
          hdr_valid <= 1'b0;
          if (turn_cnt == '0) state <= IDLE;
          else                turn_cnt <= turn_cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase

      // Release the bus at the ending edge; hdr_valid lingers through the frame_done cycle.
      if (fin) begin
        gnt        <= '0;
        bus_busy   <= 1'b0;
        state      <= TURN;
        turn_cnt   <= TURN_LOAD;
        frame_done <= (fin_err == ERR_NONE);
        if (fin_err != ERR_NONE && err == ERR_NONE) err <= fin_err;
        if (owner_id != ID_CTRL) ptr <= rr_next(owner_id);
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (MAX_BEATS=8, TIMEOUT_CYC=10).
module tb_bus_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int MAX_BEATS   = 8;
  localparam int TURNAROUND  = 1;
  localparam int TIMEOUT_CYC = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       bus_valid = 1'b0;
  logic [7:0] bus_data = '0;
  logic       ack = 1'b0;
  logic [3:0] gnt;
  logic [1:0] owner_id, hdr_src, hdr_dst, err;
  logic       bus_busy, hdr_valid, frame_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_arbiter #(
    .NUM_REQ(NUM_REQ), .MAX_BEATS(MAX_BEATS),
    .TURNAROUND(TURNAROUND), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .bus_valid(bus_valid), .bus_data(bus_data),
    .ack(ack), .gnt(gnt), .owner_id(owner_id), .bus_busy(bus_busy), .hdr_src(hdr_src),
    .hdr_dst(hdr_dst), .hdr_valid(hdr_valid), .frame_done(frame_done), .err(err)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    bus_valid = 1'b0;
    ack       = 1'b0;
    bus_data  = '0;
  endtask

  task automatic do_reset;
    idle_in();
    req   = '0;
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Expects the grant on the next edge, then drives nbeats beats with ack on the last.
  task automatic run_frame(input logic [1:0] id, input logic [1:0] src, input int nbeats);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    tick();
    chk("grant", 8'(gnt), 8'(oh));
    chk("owner", 8'(owner_id), 8'(id));
    for (int b = 0; b < nbeats; b++) begin
      bus_valid = 1'b1;
      bus_data  = {2'b00, 2'd2, src, 2'b00};
      ack       = (b == nbeats - 1);
      tick();
    end
    chk("frame_done", 8'(frame_done), 8'h01);
    chk("gnt_release", 8'(gnt), 8'h00);
    idle_in();
    tick();
    chk("turn_gap", 8'(gnt), 8'h00);
    chk("done_pulse", 8'(frame_done), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    tick();
    chk("rst_gnt", 8'(gnt), 8'h00);
    chk("rst_busy", 8'(bus_busy), 8'h00);
    chk("rst_err", 8'(err), 8'h00);
    chk("rst_hdr", 8'({hdr_valid, hdr_src, hdr_dst, frame_done, owner_id}), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Single request, 4-beat frame with header 8'h14
    req = 4'b0010;
    tick();
    chk("t1_gnt", 8'(gnt), 8'h02);
    chk("t1_owner", 8'(owner_id), 8'h01);
    chk("t1_busy", 8'(bus_busy), 8'h01);
    req = '0;
    bus_valid = 1'b1; bus_data = 8'h14;
    tick();
    chk("t1_src", 8'(hdr_src), 8'h01);
    chk("t1_dst", 8'(hdr_dst), 8'h01);
    chk("t1_hvld", 8'(hdr_valid), 8'h01);
    bus_data = 8'hA5; tick();
    bus_data = 8'h5A; tick();
    chk("t1_hold", 8'(gnt), 8'h02);
    bus_data = 8'h3C; ack = 1'b1; tick();
    chk("t1_done", 8'(frame_done), 8'h01);
    chk("t1_rel", 8'(gnt), 8'h00);
    chk("t1_busy0", 8'(bus_busy), 8'h00);
    idle_in(); tick();
    chk("t1_turn", 8'(gnt), 8'h00);
    chk("t1_hvld0", 8'(hdr_valid), 8'h00);

    // Contention: round-robin 0,1,2 then control first
    do_reset();
    req = 4'b0111;
    run_frame(2'd0, 2'd0, 2);
    run_frame(2'd1, 2'd1, 3);
    run_frame(2'd2, 2'd2, 2);
    req = 4'b1111;
    run_frame(2'd3, 2'd1, 2);
    chk("ctrl_nochk", 8'(err), 8'h00);

    // ack outside a tenure, then header source mismatch
    do_reset();
    bus_valid = 1'b1; ack = 1'b1; tick();
    chk("stray_ack", 8'({frame_done, bus_busy}), 8'h00);
    idle_in();
    req = 4'b0100; tick();
    chk("t3_gnt", 8'(gnt), 8'h04);
    req = '0;
    bus_valid = 1'b1; bus_data = 8'h04; tick();
    chk("t3_err", 8'(err), 8'h01);
    chk("t3_rel", 8'(gnt), 8'h00);
    chk("t3_nodone", 8'(frame_done), 8'h00);
    chk("t3_src", 8'(hdr_src), 8'h01);
    idle_in(); tick();
    chk("t3_hvld0", 8'(hdr_valid), 8'h00);

    // Length overrun: 9 beats without ack
    do_reset();
    req = 4'b0001; tick();
    chk("t4_gnt", 8'(gnt), 8'h01);
    req = '0;
    bus_valid = 1'b1; bus_data = 8'h00;
    for (int b = 1; b <= 7; b++) tick();
    chk("t4_beat7", 8'({err, gnt}), 8'h01);
    tick();
    chk("t4_err", 8'(err), 8'h02);
    chk("t4_rel", 8'(gnt), 8'h00);
    chk("t4_nodone", 8'(frame_done), 8'h00);
    tick();
    chk("t4_ninth", 8'({err, gnt}), 8'h20);
    idle_in();

    // Single-beat frame: header with ack; err stays sticky at 2
    req = 4'b0010; tick();
    chk("t5_gnt", 8'(gnt), 8'h02);
    req = '0;
    bus_valid = 1'b1; bus_data = 8'h14; ack = 1'b1; tick();
    chk("t5_done", 8'(frame_done), 8'h01);
    chk("t5_hvld", 8'(hdr_valid), 8'h01);
    chk("t5_rel", 8'(gnt), 8'h00);
    chk("t5_sticky", 8'(err), 8'h02);
    idle_in(); tick();
    chk("t5_after", 8'({frame_done, hdr_valid}), 8'h00);

    // Stalled owner
    do_reset();
    req = 4'b0001; tick();
    req = '0;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int c = 1; c <= 9; c++) tick();
    chk("tmo_early", 8'({err, gnt}), 8'h01);
    tick();
    chk("tmo_err", 8'(err), 8'h03);
    chk("tmo_rel", 8'(gnt), 8'h00);
    tick();
`else
    for (int c = 1; c <= 20; c++) tick();
    chk("notmo_hold", 8'({err, gnt}), 8'h01);
    bus_valid = 1'b1; bus_data = 8'h00; ack = 1'b1; tick();
    chk("notmo_done", 8'(frame_done), 8'h01);
    idle_in(); tick();
`endif

    // Reset mid-XFER; pointer is 1 here, so owner 1 wins first
    req = 4'b0111; tick();
    chk("t6_gnt", 8'(gnt), 8'h02);
    bus_valid = 1'b1; bus_data = 8'h04; tick();
    bus_data = 8'hFF; tick();
    idle_in();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async", 8'({gnt, bus_busy, hdr_valid, owner_id}), 8'h00);
    chk("t6_hdr", 8'({hdr_src, hdr_dst, err, frame_done}), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_ptr0", 8'(gnt), 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
